// File: rtl/microcode_sequencer_pkg.sv
// Shared control package: control word layout, sequencer states, microword field
// positions and the microword decoder used by microcode_sequencer.
package microcode_sequencer_pkg;

  localparam int MICRO_INSTRUCTION_WORD_WIDTH = 14;
  localparam int ROM_ADDR_WIDTH               = 9;
  localparam logic [7:0] HALT_OPCODE          = 8'hFF;

  localparam int MW_ALU_MSB    = 13;
  localparam int MW_ALU_LSB    = 10;
  localparam int MW_MEM_MSB    = 9;
  localparam int MW_MEM_LSB    = 7;
  localparam int MW_BUS        = 6;
  localparam int MW_LOAD_VALID = 5;
  localparam int MW_LOAD_MSB   = 4;
  localparam int MW_LOAD_LSB   = 3;
  localparam int MW_EN_MSB     = 2;
  localparam int MW_EN_LSB     = 1;
  localparam int MW_LAST       = 0;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;

  localparam logic [2:0] MEM_NOP   = 3'd0;
  localparam logic [2:0] MEM_READ  = 3'd1;
  localparam logic [2:0] MEM_WRITE = 3'd2;

  localparam logic BUS_PC   = 1'b0;
  localparam logic BUS_DATA = 1'b1;

  localparam logic [1:0] REG_NOP    = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_ENABLE = 2'd2;

  typedef enum logic [1:0] {INIT, FETCH, EXEC, HALT} seq_state_e;

  // reg_op is indexed by register number: 0=rax, 1=rbx, 2=rcx, 3=rdx
  typedef struct packed {
    logic            reset;
    logic            halt;
    logic            control_unit_load;
    logic            next_instr;
    logic [2:0]      memory_op;
    logic            bus_selector;
    logic [3:0]      alu_op;
    logic            alu_enable;
    logic            data_word_selector;
    logic [3:0][1:0] reg_op;
  } control_word_t;

  function automatic control_word_t decode_microword(
    input logic [MICRO_INSTRUCTION_WORD_WIDTH-1:0] mw,
    input logic                                    data_sel
  );
    control_word_t cw;
    logic          load_valid;
    logic [1:0]    load_idx;
    logic [1:0]    en_idx;
    logic          en_allowed;
    cw                    = '0;
    cw.alu_op             = mw[MW_ALU_MSB:MW_ALU_LSB];
    cw.alu_enable         = (cw.alu_op != ALU_NOP);
    cw.memory_op          = mw[MW_MEM_MSB:MW_MEM_LSB];
    cw.bus_selector       = mw[MW_BUS];
    cw.data_word_selector = data_sel;
    load_valid            = mw[MW_LOAD_VALID];
    load_idx              = mw[MW_LOAD_MSB:MW_LOAD_LSB];
    en_idx                = mw[MW_EN_MSB:MW_EN_LSB];
    en_allowed            = load_valid && (cw.alu_op == ALU_NOP) && (cw.memory_op != MEM_READ);
    // Load is checked first so it wins when both targets name the same register
    for (int r = 0; r < 4; r++) begin
      if (load_valid && (load_idx == 2'(r))) begin
        cw.reg_op[r] = REG_LOAD;
      end else if (en_allowed && (en_idx == 2'(r))) begin
        cw.reg_op[r] = REG_ENABLE;
      end else begin
        cw.reg_op[r] = REG_NOP;
      end
    end
    return cw;
  endfunction

endpackage

// File: rtl/microcode_sequencer_rom.sv
// Combinational microcode store addressed by {opcode[4:0], step}; a few hand-written
// programs plus a generated default pattern for the remaining opcodes.
module microcode_rom
  import microcode_sequencer_pkg::*;
(
  input  logic [ROM_ADDR_WIDTH-1:0]               addr,
  output logic [MICRO_INSTRUCTION_WORD_WIDTH-1:0] data
);

  logic [4:0] op;
  logic [3:0] stp;

  assign op  = addr[8:4];
  assign stp = addr[3:0];

  // Opcode 5 never sets last so the step watchdog is what ends it
  always_comb begin
    data = '0;
    case (op)
      5'd1: data = {ALU_NOP, MEM_NOP, BUS_PC, 1'b1, 2'd3, 2'd1, (stp == 4'd1)};
      5'd3: begin
        case (stp)
          4'd0:    data = {ALU_NOP, MEM_READ,  BUS_DATA, 1'b1, 2'd0, 2'd0, 1'b0};
          4'd1:    data = {ALU_ADD, MEM_NOP,   BUS_PC,   1'b1, 2'd1, 2'd0, 1'b0};
          4'd2:    data = {ALU_NOP, MEM_WRITE, BUS_DATA, 1'b1, 2'd2, 2'd2, 1'b1};
          default: data = '0;
        endcase
      end
      5'd5: data = {stp, MEM_NOP, BUS_PC, 1'b1, stp[1:0], stp[3:2], 1'b0};
      default: data = {2'b00, stp[1:0], ((op[2] && stp[0]) ? MEM_WRITE : MEM_NOP),
                       stp[0], op[0], stp[1:0], op[2:1], (stp[1:0] == op[1:0])};
    endcase
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: INIT/FETCH/EXEC/HALT control FSM driving a decoded control word.
// Define CU_MEM_WAIT_EN to add the mem_ready handshake that stalls memory cycles.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    instr,
  input  logic          flag_zero,
  input  logic          flag_carry,
`ifdef CU_MEM_WAIT_EN
  input  logic          mem_ready,
`endif
  output control_word_t control_word,
  output logic [3:0]    step,
  output logic          halted
);

  seq_state_e state;
  seq_state_e state_next;
  logic [7:0] ir;
  logic       zero_q;
  logic       carry_q;
  logic       cond_true;
  logic       stall;
  logic [MICRO_INSTRUCTION_WORD_WIDTH-1:0] microword;

  microcode_rom u_rom (
    .addr ({ir[4:0], step}),
    .data (microword)
  );

  always_comb begin
    case (ir[6:5])
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = zero_q;
      2'b10:   cond_true = carry_q;
      default: cond_true = !zero_q;
    endcase
  end

  always_comb begin
    state_next   = state;
    control_word = '0;
    stall        = 1'b0;
    case (state)
      INIT: begin
        control_word.reset = 1'b1;
        state_next         = FETCH;
      end
      FETCH: begin
        control_word.control_unit_load = 1'b1;
        control_word.memory_op         = MEM_READ;
        control_word.bus_selector      = BUS_PC;
        state_next = (instr == HALT_OPCODE) ? HALT : EXEC;
      end
      EXEC: begin
        if (!cond_true) begin
          control_word.next_instr = 1'b1;
          state_next              = FETCH;
        end else begin
          control_word = decode_microword(microword, ir[7]);
          // Step 15 ends the program even without a last bit so step never wraps
          if (microword[MW_LAST] || (step == 4'hF)) begin
            control_word.next_instr = 1'b1;
            state_next              = FETCH;
          end
        end
      end
      HALT: control_word.halt = 1'b1;
      default: state_next = INIT;
    endcase
`ifdef CU_MEM_WAIT_EN
    stall = !mem_ready && ((state == FETCH) || (state == EXEC)) &&
            ((control_word.memory_op == MEM_READ) || (control_word.memory_op == MEM_WRITE));
`endif
    if (reset) begin
      control_word       = '0;
      control_word.reset = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= INIT;
      step    <= 4'd0;
      ir      <= 8'd0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (!stall) begin
      state <= state_next;
      if (state == FETCH) begin
        ir      <= instr;
        zero_q  <= flag_zero;
        carry_q <= flag_carry;
        step    <= 4'd0;
      end else if ((state == EXEC) && (state_next == EXEC)) begin
        step <= step + 4'd1;
      end
    end
  end

  assign halted = (state == HALT);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: vector table, hand-written corner
// sequences and randomized instructions checked against a trace-level model.
module tb_microcode_sequencer;
  import microcode_sequencer_pkg::*;

  logic          clk;
  logic          reset;
  logic [7:0]    instr;
  logic          flag_zero;
  logic          flag_carry;
`ifdef CU_MEM_WAIT_EN
  logic          mem_ready;
`endif
  control_word_t control_word;
  logic [3:0]    step;
  logic          halted;

  int n_checks;
  int n_fail;

  microcode_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
`ifdef CU_MEM_WAIT_EN
    .mem_ready    (mem_ready),
`endif
    .control_word (control_word),
    .step         (step),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] instr;
    logic       zf;
    logic       cf;
    int         exp_exec;
  } vec_t;

  typedef struct {
    control_word_t cw;
    logic [3:0]    stp;
  } exp_t;

  vec_t          vecs[12];
  exp_t          exp_q[$];
  control_word_t fetch_cw;
  control_word_t reset_cw;
  control_word_t halt_cw;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] i, input logic zf, input logic cf);
    instr      = i;
    flag_zero  = zf;
    flag_carry = cf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference microcode contents, written field by field
  function automatic logic [13:0] model_rom(input logic [4:0] op, input logic [3:0] s);
    logic [3:0] alu;
    logic [2:0] mem;
    logic       bus, lv, last;
    logic [1:0] ld, en;
    alu = 4'd0; mem = 3'd0; bus = 1'b0; lv = 1'b0; ld = 2'd0; en = 2'd0; last = 1'b0;
    if (op == 5'd1) begin
      lv = 1'b1; ld = 2'd3; en = 2'd1; last = (s == 4'd1);
    end else if (op == 5'd3) begin
      if (s == 4'd0) begin mem = 3'd1; bus = 1'b1; lv = 1'b1; ld = 2'd0; end
      if (s == 4'd1) begin alu = 4'd1; lv = 1'b1; ld = 2'd1; end
      if (s == 4'd2) begin mem = 3'd2; bus = 1'b1; lv = 1'b1; ld = 2'd2; en = 2'd2; last = 1'b1; end
    end else if (op == 5'd5) begin
      alu = s; lv = 1'b1; ld = s[1:0]; en = s[3:2];
    end else begin
      alu  = {2'b00, s[1:0]};
      mem  = (op[2] && s[0]) ? 3'd2 : 3'd0;
      bus  = s[0];
      lv   = op[0];
      ld   = s[1:0];
      en   = op[2:1];
      last = (s[1:0] == op[1:0]);
    end
    return {alu, mem, bus, lv, ld, en, last};
  endfunction

  function automatic control_word_t model_decode(input logic [13:0] mw, input logic dsel);
    control_word_t cw;
    cw                    = '0;
    cw.alu_op             = mw[13:10];
    cw.alu_enable         = (mw[13:10] != 4'd0);
    cw.memory_op          = mw[9:7];
    cw.bus_selector       = mw[6];
    cw.data_word_selector = dsel;
    for (int r = 0; r < 4; r++) begin
      if (mw[5] && (int'(mw[4:3]) == r))
        cw.reg_op[r] = REG_LOAD;
      else if (mw[5] && (mw[13:10] == 4'd0) && (mw[9:7] != 3'd1) && (int'(mw[2:1]) == r))
        cw.reg_op[r] = REG_ENABLE;
      else
        cw.reg_op[r] = REG_NOP;
    end
    return cw;
  endfunction

  // Expand one fetched instruction into its expected EXEC cycle trace
  task automatic build_trace(input logic [7:0] i, input logic zf, input logic cf);
    logic          take;
    logic [13:0]   mw;
    exp_t          e;
    exp_q.delete();
    case (i[6:5])
      2'b00:   take = 1'b1;
      2'b01:   take = zf;
      2'b10:   take = cf;
      default: take = !zf;
    endcase
    if (!take) begin
      e.cw = '0;
      e.cw.next_instr = 1'b1;
      e.stp = 4'd0;
      exp_q.push_back(e);
    end else begin
      for (int s = 0; s < 16; s++) begin
        mw    = model_rom(i[4:0], 4'(s));
        e.cw  = model_decode(mw, i[7]);
        e.stp = 4'(s);
        if (mw[0] || s == 15) e.cw.next_instr = 1'b1;
        exp_q.push_back(e);
        if (mw[0]) break;
      end
    end
  endtask

  // Entered in FETCH just after a rising edge; leaves in the following FETCH
  task automatic run_instr(input logic [7:0] i, input logic zf, input logic cf, output int n_exec);
    apply_stimulus(i, zf, cf);
    #1;
    check_output("fetch_cw", 32'(control_word), 32'(fetch_cw));
    build_trace(i, zf, cf);
    n_exec = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (control_word.control_unit_load) break;
      if (n_exec < exp_q.size()) begin
        check_output("exec_cw", 32'(control_word), 32'(exp_q[n_exec].cw));
        check_output("exec_step", 32'(step), 32'(exp_q[n_exec].stp));
      end
      n_exec++;
      apply_stimulus(8'($urandom), 1'($urandom), 1'($urandom));
    end
    check_output("exec_len", 32'(n_exec), 32'(exp_q.size()));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    fetch_cw = '0;
    fetch_cw.control_unit_load = 1'b1;
    fetch_cw.memory_op         = MEM_READ;
    fetch_cw.bus_selector      = BUS_PC;
    reset_cw = '0;
    reset_cw.reset = 1'b1;
    halt_cw = '0;
    halt_cw.halt = 1'b1;

    vecs[0]  = '{8'h03, 1'b0, 1'b0, 3};
    vecs[1]  = '{8'h23, 1'b0, 1'b0, 1};
    vecs[2]  = '{8'h23, 1'b1, 1'b0, 3};
    vecs[3]  = '{8'h43, 1'b0, 1'b1, 3};
    vecs[4]  = '{8'h43, 1'b1, 1'b0, 1};
    vecs[5]  = '{8'h63, 1'b0, 1'b0, 3};
    vecs[6]  = '{8'h63, 1'b1, 1'b1, 1};
    vecs[7]  = '{8'h05, 1'b0, 1'b0, 16};
    vecs[8]  = '{8'h01, 1'b0, 1'b0, 2};
    vecs[9]  = '{8'h00, 1'b0, 1'b0, 1};
    vecs[10] = '{8'h02, 1'b0, 1'b0, 3};
    vecs[11] = '{8'h86, 1'b0, 1'b0, 3};

    reset = 1'b1;
    apply_stimulus(8'h00, 1'b0, 1'b0);
`ifdef CU_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (2) tick();
    check_output("reset_cw", 32'(control_word), 32'(reset_cw));
    reset = 1'b0;
    #1;
    check_output("init_cw", 32'(control_word), 32'(reset_cw));
    check_output("init_step", 32'(step), 32'd0);
    check_output("init_halted", 32'(halted), 32'd0);
    tick();

    foreach (vecs[k]) begin
      run_instr(vecs[k].instr, vecs[k].zf, vecs[k].cf, n);
      check_output("table_exec_len", 32'(n), 32'(vecs[k].exp_exec));
    end

    // Reset in the middle of a long program
    apply_stimulus(8'h05, 1'b0, 1'b0);
    #1;
    check_output("fetch_cw", 32'(control_word), 32'(fetch_cw));
    repeat (3) tick();
    check_output("midexec_step", 32'(step), 32'd2);
    reset = 1'b1;
    #1;
    check_output("midexec_reset_cw", 32'(control_word), 32'(reset_cw));
    tick();
    reset = 1'b0;
    #1;
    check_output("midexec_init_cw", 32'(control_word), 32'(reset_cw));
    check_output("midexec_init_step", 32'(step), 32'd0);
    tick();

    // Halt opcode holds until reset
    apply_stimulus(HALT_OPCODE, 1'b0, 1'b0);
    #1;
    check_output("fetch_cw", 32'(control_word), 32'(fetch_cw));
    for (int c = 0; c < 22; c++) begin
      tick();
      check_output("halt_flag", 32'(halted), 32'd1);
      check_output("halt_cw", 32'(control_word), 32'(halt_cw));
      apply_stimulus(8'($urandom), 1'($urandom), 1'($urandom));
    end
    reset = 1'b1;
    #1;
    check_output("halt_reset_cw", 32'(control_word), 32'(reset_cw));
    tick();
    reset = 1'b0;
    #1;
    check_output("halt_init_cw", 32'(control_word), 32'(reset_cw));
    check_output("halt_init_halted", 32'(halted), 32'd0);
    check_output("halt_init_step", 32'(step), 32'd0);
    tick();

`ifdef CU_MEM_WAIT_EN
    // READ microword stalled by mem_ready low for three edges
    apply_stimulus(8'h03, 1'b0, 1'b0);
    #1;
    check_output("fetch_cw", 32'(control_word), 32'(fetch_cw));
    tick();
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_output("wait_step", 32'(step), 32'd0);
      check_output("wait_mem_op", 32'(control_word.memory_op), 32'(MEM_READ));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_output("wait_release_step", 32'(step), 32'd0);
    tick();
    check_output("wait_advance_step", 32'(step), 32'd1);
    tick();
    check_output("wait_last_step", 32'(step), 32'd2);
    tick();
`endif

    for (int r = 0; r < 40; r++) begin
      logic [7:0] ri;
      ri = 8'($urandom);
      if (ri == HALT_OPCODE) ri = 8'h03;
      run_instr(ri, 1'($urandom), 1'($urandom), n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr  input  8  opcode on the memory data bus, sampled at the end of FETCH.
REQ-005 flag_zero  input  1  ALU zero flag, used for conditional opcodes.
REQ-006 flag_carry  input  1  ALU carry flag, used for conditional opcodes.
REQ-007 mem_ready  input  1  memory handshake; present only when CU_MEM_WAIT_EN is defined.
REQ-008 control_word  output  control_word_t  decoded control word for the current cycle.
REQ-009 step  output  4  current micro-step index.
REQ-010 halted  output  1  high while in HALT.

Function
REQ-011 The FSM SHALL have exactly four states: INIT, FETCH, EXEC, HALT.
REQ-012 INIT SHALL last one cycle, assert control_word.reset=1 and go to FETCH.
REQ-013 FETCH SHALL last one cycle and drive control_unit_load=1, memory_op=READ, bus_selector=PC, with every other field at its NOP/0 value.
REQ-014 At the FETCH->next edge the block SHALL register instr into an internal IR and clear step to 0.
REQ-015 IR==8'hFF (halt opcode) SHALL move FETCH->HALT; HALT is left only by reset.
REQ-016 In HALT, halt=1 and all other fields are NOP/0.
REQ-017 IR[6:5] is the condition code: 00 always, 01 if flag_zero, 10 if flag_carry, 11 if !flag_zero; flags are sampled at the end of FETCH.
REQ-018 Condition false: EXEC SHALL last exactly one cycle with next_instr=1 and no other activity, then return to FETCH.
REQ-019 Condition true: each EXEC cycle SHALL read the 14-bit microword at ROM address {IR[4:0], step} (9 bits) and decode it combinationally into control_word in the same cycle.
REQ-020 Microword fields: [13:10] alu_op; [9:7] memory_op; [6] bus_selector; [5] load_valid; [4:3] load register index (0=rax..3=rdx); [2:1] enable register index; [0] last.
REQ-021 Decode: alu_enable = (alu_op != ALU_NOP); selected reg_op = LOAD when load_valid; enable-reg reg_op = ENABLE when load_valid && alu_op==ALU_NOP && memory_op!=READ; all other reg_ops = REG_NOP.
REQ-022 data_word_selector SHALL equal IR[7].
REQ-023 If a register is both load and enable target, LOAD SHALL win.
REQ-024 EXEC with last=1 SHALL assert next_instr=1 and return to FETCH; otherwise step increments.
REQ-025 Watchdog: when step==15 and last=0, the block SHALL still force next_instr=1 and return to FETCH; step SHALL never wrap to 0 inside EXEC.
REQ-026 Fetch-to-fetch latency is (number of microwords up to and including last)+1 cycles.

Reset
REQ-027 reset=1 SHALL, on the next edge, force state=INIT, step=0, IR=0, halted=0.
REQ-028 During reset, control_word SHALL be all NOP/0 except reset=1.
REQ-029 Reset SHALL take effect mid-EXEC or in HALT with no memory side effect on the reset cycle.

Configuration
REQ-030 Macro CU_MEM_WAIT_EN defined: in FETCH or in EXEC with memory_op in {READ, WRITE}, mem_ready=0 SHALL hold state, step and control_word unchanged; progress resumes on the edge where mem_ready=1.
REQ-031 Macro undefined: the mem_ready port SHALL be absent and memory is treated as always ready.

Structure
REQ-032 The seq_state_e enum (INIT, FETCH, EXEC, HALT), the HALT_OPCODE constant and the microword field position constants SHALL live in the shared control package beside control_word_t.
REQ-033 Microcode storage SHALL be a sub-module microcode_rom (9-bit address in, MICRO_INSTRUCTION_WORD_WIDTH data out, combinational read).
REQ-034 Decode SHALL be a package function.

Verification
REQ-035 Reset release: reset 1->0 -> one cycle with reset=1, then FETCH with control_unit_load=1, memory_op=READ, bus_selector=PC.
REQ-036 instr=8'h03 with a 3-microword program (last on step 2) -> EXEC steps 0,1,2; next_instr on step 2; FETCH again 4 cycles after the previous FETCH.
REQ-037 instr=8'h23 with flag_zero=0 -> a single EXEC cycle with next_instr=1 only; with flag_zero=1 -> full program executes.
REQ-038 instr=8'hFF -> halted=1 and control_word.halt=1 held for 20+ cycles; reset -> INIT.
REQ-039 Program with no last bit -> next_instr forced at step 15 and return to FETCH.
REQ-040 CU_MEM_WAIT_EN defined, mem_ready=0 for 3 cycles during a READ step -> step frozen for 3 cycles, advances on the first mem_ready=1 edge.
